store_wbuffer: RTL and testbench
================================

// Module: store_wbuffer
// PURPOSE
//  Parametrised in-order store write buffer between write-back and the D-cache/memory port.
//  Write-back enqueues committed store pieces (PA, data, size, EIP); the buffer drains them oldest-first.
//  Drain uses a valid/ready handshake. Write-back is stalled only when the buffer is full.
//  Optional store-to-load forwarding for younger loads.
// PARAMETERS
//  DEPTH   4   entries; power of 2, >=2
//  PA_W    15  physical address width
//  DATA_W  32  store data width; byte lanes = DATA_W/8
//  EIP_W   32  EIP tag width, carried for debug/exception reporting
// PORTS
//  clk        in   1       clock
//  rst        in   1       asynchronous, active-low reset
//  enq_v      in   1       write-back presents a store piece this cycle
//  enq_pa     in   PA_W    store physical address
//  enq_data   in   DATA_W  store data, right-aligned
//  enq_size   in   2       size code: 00=4B, 01=1B, 10=2B, 11=3B
//  enq_eip    in   EIP_W   EIP of the storing instruction
//  stall      out  1       enq_v & full; write-back must hold the piece
//  full       out  1       count==DEPTH
//  empty      out  1       count==0; used to serialise fences/self-modifying code
//  mem_v      out  1       head entry valid toward memory
//  mem_pa     out  PA_W    head PA
//  mem_data   out  DATA_W  head data
//  mem_size   out  2       head size code
//  mem_eip    out  EIP_W   head EIP
//  mem_rdy    in   1       memory accepts the head this cycle
//  ld_v       in   1       load lookup (forwarding)
//  ld_pa      in   PA_W    load address
//  ld_size    in   2       load size code
//  ld_hit     out  1       forward ld_data to the load
//  ld_data    out  DATA_W  forwarded data
//  ld_conflict out 1       partial overlap; the load must retry
// BEHAVIOUR
//  - Circular FIFO. Registers: wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap), count (log2 DEPTH+1 bits).
//  - Reset (rst=0, async): pointers=0, count=0, all entry valids=0.
//    empty=1, full=0, stall=0, mem_v=0, ld_hit=0, ld_conflict=0.
//    Reset mid-drain discards all entries.
//  - Enqueue: enq_v & ~full writes the entry at wr_ptr on the clk edge; wr_ptr+1.
//  - Full blocks enqueue even if a pop happens the same cycle. There is no mem_rdy->stall combinational path.
//  - Dequeue: pop = mem_v & mem_rdy; rd_ptr+1 on the edge. mem_* are driven from the head entry, zero-latency read.
//    mem_* hold stable while mem_v & ~mem_rdy.
//  - Simultaneous enqueue and pop (not full): count is unchanged; both pointers advance.
//  - Enqueue into an empty buffer: mem_v=1 the next cycle; no bypass. Minimum latency is 1 cycle, enq to mem_v.
//  - mem_* outputs are 0 when empty.
//  - enq_v=0 or full: no state change from the enqueue side.
//  - Lengths: size code -> bytes {4,1,2,3}.
//    Byte range is [pa, pa+len), computed in PA_W+1 bits; ranges do not wrap at 2^PA_W.
// CONFIGURATION
//  WBUF_FWD_EN defined (forwarding):
//   - ld_hit, ld_data and ld_conflict are combinational from the ld_* inputs and current entries.
//   - Find the youngest valid entry whose byte range overlaps the load range.
//     Search order: wr_ptr-1 down to rd_ptr.
//   - If that entry has the same pa and size as the load: ld_hit=1 and ld_data=entry data masked to the load length.
//   - Otherwise, on any overlap: ld_conflict=1.
//   - No overlap, or ld_v=0: both flags are 0.
//   - An entry popping this cycle still counts as valid for the lookup.
//  WBUF_FWD_EN undefined:
//   - ld_hit=0, ld_conflict=0 and ld_data=0 permanently.
//   - ld_* inputs are ignored; no comparator logic is built.
// STRUCTURE
//  - wbuf_pkg holds:
//    - size-code constants (SZ_4B=2'b00, SZ_1B=2'b01, SZ_2B=2'b10, SZ_3B=2'b11);
//    - a size-to-length function;
//    - the entry record {pa, data, size, eip}.
//  - One sub-module, wbuf_entry_cmp: per-entry overlap and exact-match check.
//    Inputs: entry pa/size and load pa/size. Outputs: overlap, exact.
//    Instantiated DEPTH times only under WBUF_FWD_EN.
//  - Youngest-match priority select lives in store_wbuffer.
// TESTING
//  1. Reset, then enq 0x0100/0xDEADBEEF/SZ_4B with mem_rdy=0.
//     -> next cycle mem_v=1, mem_pa=0x0100, mem_data=0xDEADBEEF, empty=0.
//     mem_rdy=1 -> empty=1 the cycle after.
//  2. DEPTH=4, mem_rdy=0, enq 5 stores.
//     -> full=1 after the 4th; 5th sees stall=1 and the buffer is unchanged.
//     mem_rdy=1 for 4 cycles -> PAs drain in enqueue order, then empty=1.
//  3. Full, with enq_v=1 and mem_rdy=1 in the same cycle.
//     -> pop occurs, enqueue rejected (stall=1), count=3. Next cycle the enqueue is accepted, count=4.
//  4. Continuous enq+pop for 3*DEPTH cycles with an incrementing data pattern.
//     -> pointers wrap, output sequence is identical to the input, count is constant.
//  5. (WBUF_FWD_EN) Stores 0x0200/0x11223344/SZ_4B then 0x0200/0xAABBCCDD/SZ_4B.
//     Load 0x0200/SZ_4B -> ld_hit=1, ld_data=0xAABBCCDD.
//     Load 0x0201/SZ_1B -> ld_conflict=1, ld_hit=0.
//     Load 0x0300 -> both 0.
//  6. Assert rst low with 3 entries and mem_v=1.
//     -> immediately mem_v=0, empty=1, full=0. After release, no stale entry reappears.

Source files
------------

// File: rtl/wbuf_pkg.sv
// Shared definitions for the store write buffer: size codes, size-to-length helper
// and the buffered store entry record.
package wbuf_pkg;

  localparam logic [1:0] SZ_4B = 2'b00;
  localparam logic [1:0] SZ_1B = 2'b01;
  localparam logic [1:0] SZ_2B = 2'b10;
  localparam logic [1:0] SZ_3B = 2'b11;

  localparam int WBUF_PA_W   = 15;
  localparam int WBUF_DATA_W = 32;
  localparam int WBUF_EIP_W  = 32;

  function automatic logic [2:0] size_len(input logic [1:0] sz);
    case (sz)
      SZ_1B:   size_len = 3'd1;
      SZ_2B:   size_len = 3'd2;
      SZ_3B:   size_len = 3'd3;
      default: size_len = 3'd4;
    endcase
  endfunction

  typedef struct packed {
    logic [WBUF_PA_W-1:0]   pa;
    logic [WBUF_DATA_W-1:0] data;
    logic [1:0]             size;
    logic [WBUF_EIP_W-1:0]  eip;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_entry_cmp.sv
// Per-entry byte-range comparator: overlap of [pa, pa+len) ranges and exact pa/size match.
module wbuf_entry_cmp
  import wbuf_pkg::*;
#(
  parameter int PA_W = 15
) (
  input  logic [PA_W-1:0] e_pa,
  input  logic [1:0]      e_size,
  input  logic [PA_W-1:0] l_pa,
  input  logic [1:0]      l_size,
  output logic            overlap,
  output logic            exact
);

  logic [PA_W:0] e_start, e_end, l_start, l_end;

  // One extra bit keeps ranges near the top of the address space from wrapping.
  assign e_start = {1'b0, e_pa};
  assign l_start = {1'b0, l_pa};
  assign e_end   = e_start + (PA_W+1)'(size_len(e_size));
  assign l_end   = l_start + (PA_W+1)'(size_len(l_size));

  assign overlap = (e_start < l_end) && (l_start < e_end);
  assign exact   = (e_pa == l_pa) && (e_size == l_size);

endmodule

// File: rtl/store_wbuffer.sv
// In-order store write buffer draining oldest-first over a valid/ready port.
// Define WBUF_FWD_EN to build store-to-load forwarding for younger loads.
module store_wbuffer
  import wbuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PA_W   = WBUF_PA_W,
  parameter int DATA_W = WBUF_DATA_W,
  parameter int EIP_W  = WBUF_EIP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_v,
  input  logic [PA_W-1:0]   enq_pa,
  input  logic [DATA_W-1:0] enq_data,
  input  logic [1:0]        enq_size,
  input  logic [EIP_W-1:0]  enq_eip,
  output logic              stall,
  output logic              full,
  output logic              empty,
  output logic              mem_v,
  output logic [PA_W-1:0]   mem_pa,
  output logic [DATA_W-1:0] mem_data,
  output logic [1:0]        mem_size,
  output logic [EIP_W-1:0]  mem_eip,
  input  logic              mem_rdy,
  input  logic              ld_v,
  input  logic [PA_W-1:0]   ld_pa,
  input  logic [1:0]        ld_size,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_conflict
);

  localparam int PTR_W = $clog2(DEPTH);

  wbuf_entry_t       entries [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              push, pop;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign stall = enq_v & full;
  assign push  = enq_v & ~full;
  assign mem_v = valid[rd_ptr];
  assign pop   = mem_v & mem_rdy;

  assign mem_pa   = mem_v ? entries[rd_ptr].pa   : '0;
  assign mem_data = mem_v ? entries[rd_ptr].data : '0;
  assign mem_size = mem_v ? entries[rd_ptr].size : '0;
  assign mem_eip  = mem_v ? entries[rd_ptr].eip  : '0;

  // Control state: pointers, occupancy and per-entry valids
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage, qualified by valid
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_ptr] <= '{pa: enq_pa, data: enq_data, size: enq_size, eip: enq_eip};
    end
  end

`ifdef WBUF_FWD_EN
  logic [DEPTH-1:0] ovl, exact;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    wbuf_entry_cmp #(.PA_W(PA_W)) u_cmp (
      .e_pa    (entries[g].pa),
      .e_size  (entries[g].size),
      .l_pa    (ld_pa),
      .l_size  (ld_size),
      .overlap (ovl[g]),
      .exact   (exact[g])
    );
  end

  // Youngest overlapping entry wins; scanning from wr_ptr-1 backwards visits live entries youngest-first.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    logic [DATA_W-1:0] mask;
    ld_hit      = 1'b0;
    ld_conflict = 1'b0;
    ld_data     = '0;
    found       = 1'b0;
    idx         = '0;
    mask        = '0;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (b < int'(size_len(ld_size))) mask[b*8 +: 8] = 8'hFF;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = wr_ptr - PTR_W'(i + 1);
      if (ld_v && !found && valid[idx] && ovl[idx]) begin
        found = 1'b1;
        if (exact[idx]) begin
          ld_hit  = 1'b1;
          ld_data = entries[idx].data & mask;
        end else begin
          ld_conflict = 1'b1;
        end
      end
    end
  end
`else
  logic unused_ld;
  assign unused_ld   = ^{ld_v, ld_pa, ld_size};
  assign ld_hit      = 1'b0;
  assign ld_conflict = 1'b0;
  assign ld_data     = '0;
`endif

endmodule

// File: tb/tb_store_wbuffer.sv
// Self-checking bench for store_wbuffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_store_wbuffer;
  import wbuf_pkg::*;

  localparam int DEPTH  = 4;
  localparam int PA_W   = 15;
  localparam int DATA_W = 32;
  localparam int EIP_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              enq_v;
  logic [PA_W-1:0]   enq_pa;
  logic [DATA_W-1:0] enq_data;
  logic [1:0]        enq_size;
  logic [EIP_W-1:0]  enq_eip;
  logic              stall, full, empty, mem_v;
  logic [PA_W-1:0]   mem_pa;
  logic [DATA_W-1:0] mem_data;
  logic [1:0]        mem_size;
  logic [EIP_W-1:0]  mem_eip;
  logic              mem_rdy;
  logic              ld_v;
  logic [PA_W-1:0]   ld_pa;
  logic [1:0]        ld_size;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              ld_conflict;

  store_wbuffer #(.DEPTH(DEPTH), .PA_W(PA_W), .DATA_W(DATA_W), .EIP_W(EIP_W)) dut (
    .clk(clk), .rst(rst),
    .enq_v(enq_v), .enq_pa(enq_pa), .enq_data(enq_data), .enq_size(enq_size), .enq_eip(enq_eip),
    .stall(stall), .full(full), .empty(empty),
    .mem_v(mem_v), .mem_pa(mem_pa), .mem_data(mem_data), .mem_size(mem_size), .mem_eip(mem_eip),
    .mem_rdy(mem_rdy),
    .ld_v(ld_v), .ld_pa(ld_pa), .ld_size(ld_size),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PA_W-1:0]   pa;
    logic [DATA_W-1:0] data;
    logic [1:0]        size;
    logic [EIP_W-1:0]  eip;
  } ment_t;

  ment_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int blen(input logic [1:0] s);
    return (s == 2'b00) ? 4 : int'(s);
  endfunction

  task automatic check_all(input string tag);
    bit e, f;
    logic eh, ec;
    logic [63:0] ed;
    e = (q.size() == 0);
    f = (q.size() == DEPTH);
    chk({tag, ".empty"}, 64'(empty), 64'(e));
    chk({tag, ".full"},  64'(full),  64'(f));
    chk({tag, ".stall"}, 64'(stall), 64'(enq_v & f));
    chk({tag, ".mem_v"}, 64'(mem_v), 64'(!e));
    chk({tag, ".mem_pa"},   64'(mem_pa),   e ? 64'd0 : 64'(q[0].pa));
    chk({tag, ".mem_data"}, 64'(mem_data), e ? 64'd0 : 64'(q[0].data));
    chk({tag, ".mem_size"}, 64'(mem_size), e ? 64'd0 : 64'(q[0].size));
    chk({tag, ".mem_eip"},  64'(mem_eip),  e ? 64'd0 : 64'(q[0].eip));
    eh = 1'b0; ec = 1'b0; ed = '0;
`ifdef WBUF_FWD_EN
    if (ld_v) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        int es, ee, ls, le;
        es = int'(q[i].pa);  ee = es + blen(q[i].size);
        ls = int'(ld_pa);    le = ls + blen(ld_size);
        if (es < le && ls < ee) begin
          if (q[i].pa == ld_pa && q[i].size == ld_size) begin
            eh = 1'b1;
            ed = 64'(q[i].data) & ((64'd1 << (8 * blen(ld_size))) - 64'd1);
          end else begin
            ec = 1'b1;
          end
          break;
        end
      end
    end
`endif
    chk({tag, ".ld_hit"},      64'(ld_hit),      64'(eh));
    chk({tag, ".ld_conflict"}, 64'(ld_conflict), 64'(ec));
    chk({tag, ".ld_data"},     64'(ld_data),     ed);
  endtask

  // Check current outputs, then advance one clock and update the model.
  task automatic tick(input string tag);
    bit do_push, do_pop;
    ment_t ne;
    #1;
    check_all(tag);
    do_push = enq_v && (q.size() < DEPTH);
    do_pop  = (q.size() > 0) && mem_rdy;
    ne = '{pa: enq_pa, data: enq_data, size: enq_size, eip: enq_eip};
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(ne);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [PA_W-1:0] pa, input logic [DATA_W-1:0] d,
                         input logic [1:0] sz);
    enq_v = v; enq_pa = pa; enq_data = d; enq_size = sz; enq_eip = 32'h8000_0000 | 32'(pa);
  endtask

  initial begin
    rst = 1'b0; mem_rdy = 1'b0; ld_v = 1'b0; ld_pa = '0; ld_size = SZ_4B;
    set_enq(1'b0, '0, '0, SZ_4B);
    #12;
    chk("rst.empty", 64'(empty), 64'd1);
    chk("rst.full",  64'(full),  64'd0);
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.mem_v", 64'(mem_v), 64'd0);
    chk("rst.ld_hit", 64'(ld_hit), 64'd0);
    chk("rst.ld_conflict", 64'(ld_conflict), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Scenario 1: single store, one-cycle latency, then drain
    set_enq(1'b1, 15'h0100, 32'hDEADBEEF, SZ_4B);
    tick("t1_enq");
    set_enq(1'b0, '0, '0, SZ_4B);
    #1;
    chk("t1.mem_v",    64'(mem_v),    64'd1);
    chk("t1.mem_pa",   64'(mem_pa),   64'h0100);
    chk("t1.mem_data", 64'(mem_data), 64'hDEADBEEF);
    chk("t1.empty",    64'(empty),    64'd0);
    mem_rdy = 1'b1;
    tick("t1_pop");
    mem_rdy = 1'b0;
    chk("t1.empty_after", 64'(empty), 64'd1);

    // Scenario 2: overfill, stall on the fifth, drain in order
    for (int i = 0; i < 5; i++) begin
      set_enq(1'b1, 15'(16'h0010 + i), 32'h1000 + 32'(i), SZ_4B);
      if (i == 4) begin
        #1;
        chk("t2.stall", 64'(stall), 64'd1);
      end
      tick("t2_fill");
      if (i == 3) chk("t2.full", 64'(full), 64'd1);
    end
    set_enq(1'b0, '0, '0, SZ_4B);
    mem_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2.drain_pa", 64'(mem_pa), 64'h0010 + 64'(i));
      tick("t2_drain");
    end
    mem_rdy = 1'b0;
    chk("t2.empty", 64'(empty), 64'd1);

    // Scenario 3: full with simultaneous pop and enqueue
    for (int i = 0; i < 4; i++) begin
      set_enq(1'b1, 15'(16'h0030 + i), 32'h3000 + 32'(i), SZ_2B);
      tick("t3_fill");
    end
    set_enq(1'b1, 15'h0040, 32'h4040, SZ_1B);
    mem_rdy = 1'b1;
    #1;
    chk("t3.stall", 64'(stall), 64'd1);
    tick("t3_both");
    chk("t3.full_after_pop", 64'(full), 64'd0);
    mem_rdy = 1'b0;
    tick("t3_accept");
    chk("t3.full_again", 64'(full), 64'd1);
    set_enq(1'b0, '0, '0, SZ_4B);
    mem_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3.drain_pa", 64'(mem_pa), (i < 3) ? (64'h0031 + 64'(i)) : 64'h0040);
      tick("t3_drain");
    end
    mem_rdy = 1'b0;

    // Scenario 4: continuous enqueue+pop across pointer wrap
    set_enq(1'b1, 15'h0050, 32'd1000, SZ_4B);
    tick("t4_prime");
    mem_rdy = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      set_enq(1'b1, 15'(16'h0051 + i), 32'd1001 + 32'(i), SZ_4B);
      #1;
      chk("t4.stream_data", 64'(mem_data), 64'd1000 + 64'(i));
      tick("t4_stream");
      chk("t4.not_empty", 64'(empty), 64'd0);
    end
    set_enq(1'b0, '0, '0, SZ_4B);
    tick("t4_drain");
    mem_rdy = 1'b0;

`ifdef WBUF_FWD_EN
    // Scenario 5: forwarding from the youngest matching store
    set_enq(1'b1, 15'h0200, 32'h11223344, SZ_4B);
    tick("t5_st0");
    set_enq(1'b1, 15'h0200, 32'hAABBCCDD, SZ_4B);
    tick("t5_st1");
    set_enq(1'b0, '0, '0, SZ_4B);
    ld_v = 1'b1; ld_pa = 15'h0200; ld_size = SZ_4B;
    #1;
    chk("t5.hit",  64'(ld_hit),  64'd1);
    chk("t5.data", 64'(ld_data), 64'hAABBCCDD);
    ld_pa = 15'h0201; ld_size = SZ_1B;
    #1;
    chk("t5.partial_conflict", 64'(ld_conflict), 64'd1);
    chk("t5.partial_hit",      64'(ld_hit),      64'd0);
    ld_pa = 15'h0300; ld_size = SZ_4B;
    #1;
    chk("t5.miss_hit",      64'(ld_hit),      64'd0);
    chk("t5.miss_conflict", 64'(ld_conflict), 64'd0);
    ld_v = 1'b0;
    mem_rdy = 1'b1;
    tick("t5_drain0");
    tick("t5_drain1");
    mem_rdy = 1'b0;
`endif

    // Scenario 6: asynchronous reset with entries pending
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 15'(16'h0060 + i), 32'h6000 + 32'(i), SZ_3B);
      tick("t6_fill");
    end
    set_enq(1'b0, '0, '0, SZ_4B);
    #1;
    chk("t6.mem_v_pre", 64'(mem_v), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("t6.mem_v", 64'(mem_v), 64'd0);
    chk("t6.empty", 64'(empty), 64'd1);
    chk("t6.full",  64'(full),  64'd0);
    q.delete();
    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    mem_rdy = 1'b1;
    for (int i = 0; i < 3; i++) tick("t6_after");
    mem_rdy = 1'b0;

    // Randomized traffic with overlapping addresses and loads
    for (int c = 0; c < 400; c++) begin
      logic [PA_W-1:0] rpa;
      rpa = ($urandom_range(0, 15) == 0) ? 15'(15'h7FFC + $urandom_range(0, 3))
                                         : 15'(16'h0200 + $urandom_range(0, 11));
      set_enq(1'($urandom_range(0, 1)), rpa, $urandom, 2'($urandom_range(0, 3)));
      mem_rdy = ($urandom_range(0, 2) != 0);
      ld_v    = 1'($urandom_range(0, 1));
      ld_pa   = ($urandom_range(0, 7) == 0) ? 15'(15'h7FFC + $urandom_range(0, 3))
                                            : 15'(16'h0200 + $urandom_range(0, 11));
      ld_size = 2'($urandom_range(0, 3));
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
